// File: rtl/md_unit_e.sv
// md_unit_e: E-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/MULTU(/MADD/MADDU) busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES; MTHI/MTLO write on the next edge.
// Backpressure: stall_req holds the E-stage MD op while busy; starts seen while busy are dropped.
// Optional build macro: MD_MADD_EN enables MADD (op 6) and MADDU (op 7) accumulate into {hi,lo}.
module md_unit_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Operation encodings as seen on md_op.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  // Counter reload values; both latencies fit in four bits.
  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [2:0]  op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // Decode of the incoming op: does it occupy the unit for several cycles?
  logic long_op;
  logic div_op;

  // Classify the E-stage op; MADD/MADDU only count when the feature is built in.
  always_comb begin
    long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
              (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MD_MADD_EN
    long_op = long_op || (md_op == OP_MADD) || (md_op == OP_MADDU);
`endif
    div_op  = (md_op == OP_DIV) || (md_op == OP_DIVU);
  end

  // ------------------------------------------------------------------
  // Result datapath, driven only by the operands latched at start, so
  // later changes on src_a/src_b cannot disturb an operation in flight.
  // ------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic        [31:0] a_mag, b_mag;
  logic        [31:0] q_mag, r_mag;
  logic        [31:0] divs_q, divs_r;
  logic        [31:0] divu_q, divu_r;
  logic               b_zero;

  assign prod_s = $signed(a_q) * $signed(b_q);
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign b_zero = (b_q == 32'd0);
  // A zero divisor never commits a result; substituting 1 keeps the divider free of X.
  assign b_safe = b_zero ? 32'd1 : b_q;

  // Signed divide on magnitudes, then restore signs: the quotient truncates
  // toward zero and the remainder follows the dividend. 0x8000_0000 / -1
  // naturally yields quotient 0x8000_0000 and remainder 0 this way.
  always_comb begin
    a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag  = b_q[31] ? (32'd0 - b_safe) : b_safe;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    divs_q = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    divs_r = a_q[31] ? (32'd0 - r_mag) : r_mag;
    divu_q = a_q / b_safe;
    divu_r = a_q % b_safe;
  end

  // Completion result selection: which {hi,lo} value the finishing op commits.
  logic        res_wr;
  logic [31:0] res_hi, res_lo;

  // Select the committed result by the latched opcode; divide by zero commits nothing.
  always_comb begin
    res_wr = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (op_q)
      OP_MULT: begin
        res_wr = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        res_wr = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        res_wr = !b_zero;
        res_hi = divs_r;
        res_lo = divs_q;
      end
      OP_DIVU: begin
        res_wr = !b_zero;
        res_hi = divu_r;
        res_lo = divu_q;
      end
`ifdef MD_MADD_EN
      // Accumulate into the current HI/LO; nothing else can write them while busy.
      OP_MADD: begin
        res_wr = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      end
      OP_MADDU: begin
        res_wr = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      end
`endif
      default: begin
        res_wr = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------

  // Next-state logic: start, countdown, completion write and MTHI/MTLO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          if (long_op) begin
            op_d    = md_op;
            a_d     = src_a;
            b_d     = src_b;
            cnt_d   = div_op ? DIV_N : MULT_N;
            state_d = RUN;
          end else if (md_op == OP_MTHI) begin
            hi_d = src_a;
          end else if (md_op == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      RUN: begin
        // Any md_start seen here is ignored; the hazard unit holds it via stall_req.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and architectural registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // busy comes straight from the state register, so it is glitch-free for the hazard unit.
  assign busy      = (state_q == RUN);
  assign stall_req = busy | (md_start & long_op);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: table-driven directed vectors plus randomized ops against a reference model.
// Reference computes HI/LO with plain 64-bit integer arithmetic on the architectural rules.
// Also covers busy-time starts, divide by zero and asynchronous reset mid-divide.
module tb_md_unit_e;

  logic        clk;
  logic        reset;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
    bit          interfere;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [2:0] op);
    return (op <= 3'd3) || (MADD_EN && op >= 3'd6);
  endfunction

  function automatic int ref_busy(input logic [2:0] op);
    if (!is_long(op)) return 0;
    return (op == 3'd2 || op == 3'd3) ? 10 : 5;
  endfunction

  // Architectural result of one op given the current {hi,lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] cur);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = cur;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = ua * ub;
      3'd2: if (b != 0) begin
              q   = sa / sb;
              r   = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      3'd3: if (b != 0) res = {a % b, a / b};
      3'd4: res = {a, cur[31:0]};
      3'd5: res = {cur[63:32], a};
      3'd6: if (MADD_EN) res = cur + 64'(sa * sb);
      default: if (MADD_EN) res = cur + ua * ub;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op in IDLE, optionally hammer md_start while busy, return busy length.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit interfere, output int nbusy);
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    #1;
    chk("stall_req_at_start", {31'd0, stall_req}, {31'd0, is_long(op)});
    @(negedge clk);
    md_start = 1'b0;
    md_op    = 3'($urandom_range(0, 7));
    src_a    = $urandom;
    src_b    = $urandom;
    nbusy    = 0;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      if (interfere) begin
        md_start = 1'b1;
        md_op    = 3'($urandom_range(0, 7));
        src_a    = $urandom;
        src_b    = $urandom;
      end
      #1;
      chk("stall_req_while_busy", {31'd0, stall_req}, 32'd1);
      @(negedge clk);
      md_start = 1'b0;
    end
  endtask

  vec_t        vecs[13];
  logic [63:0] model;
  int          nb;

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 3'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    model    = 64'd0;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b1};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  1'b0};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0};
    vecs[3]  = '{3'd3, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 1'b0};
    vecs[5]  = '{3'd4, 32'h0000_1234, 32'd9,         32'h0000_1234, 32'h8000_0000, 0,  1'b0};
    vecs[6]  = '{3'd5, 32'd5,         32'd9,         32'h0000_1234, 32'h0000_0005, 0,  1'b0};
    vecs[7]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5,  1'b1};
    vecs[8]  = '{3'd5, 32'hFFFF_FFFF, 32'd0,         32'h3FFF_FFFF, 32'hFFFF_FFFF, 0,  1'b0};
    vecs[9]  = '{3'd4, 32'd0,         32'd0,         32'h0000_0000, 32'hFFFF_FFFF, 0,  1'b0};
    vecs[10] = '{3'd7, 32'd1,         32'd1,
                 MADD_EN ? 32'd1 : 32'd0, MADD_EN ? 32'd0 : 32'hFFFF_FFFF, MADD_EN ? 5 : 0, 1'b0};
    vecs[11] = '{3'd6, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF,
                 MADD_EN ? 5 : 0, 1'b0};
    vecs[12] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b1};

    // Reset state.
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].interfere, nb);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      model = ref_result(vecs[i].op, vecs[i].a, vecs[i].b, model);
    end

    // Asynchronous reset during the fourth busy cycle of a divide.
    @(negedge clk);
    md_start = 1'b1;
    md_op    = 3'd2;
    src_a    = 32'd100;
    src_b    = 32'd7;
    @(negedge clk);
    md_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model = 64'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_lo", lo, 32'd0);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
      run_op(op, a, b, bit'($urandom_range(0, 1)), nb);
      model = ref_result(op, a, b, model);
      chk($sformatf("rnd%0d_op%0d_busy_cycles", i, op), 32'(nb), 32'(ref_busy(op)));
      chk($sformatf("rnd%0d_op%0d_hi", i, op), hi, model[63:32]);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), lo, model[31:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit_e.md
Name: md_unit_e

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Consumes the operand pair that the D->E pipeline register presents in E (RF_RD1_E, RF_RD2_E).
- Owns the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter so the hazard unit can stall D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU); legal range 1..15
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
- clk  input  1  pipeline clock, all state updates on posedge
- reset  input  1  asynchronous active-high reset
- md_start  input  1  E-stage instruction is an MD op; sampled on posedge
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
- src_a  input  32  rs operand (forwarded RF_RD1_E)
- src_b  input  32  rt operand (forwarded RF_RD2_E)
- busy  output  1  registered; high while an operation is in flight
- stall_req  output  1  combinational: busy | (md_start & op is mult/div class)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - The in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE, md_start=1, op in {0,1,2,3} (or {6,7} when enabled):
  - Latch src_a, src_b and md_op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the following cycle.
- RUN:
  - Counter decrements every cycle.
  - On the edge where counter goes 1->0: hi/lo take the result, busy drops to 0, state returns to IDLE.
  - busy is high for exactly N cycles after the start edge.
  - The new hi/lo values are visible in the same cycle that busy is first low.
- md_start while busy=1: ignored, with no effect on the operands, counter or hi/lo.
  - The hazard unit must keep the instruction stalled in E/D via stall_req.
  - This includes the final busy cycle; there is no back-to-back overlap.
- MTHI/MTLO in IDLE: hi (or lo) <= src_a on the next posedge; busy stays 0.
- MTHI/MTLO while busy: ignored.
- Result rules:
  - MULT: {hi,lo} = signed(a)*signed(b), 64-bit.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Divide by zero (b=0):
  - The operation runs the full DIV_CYCLES with busy asserted.
  - hi and lo are left unchanged at completion.
- The result is computed from the latched operands only. src_a/src_b changing during RUN has no effect.
- stall_req has no dependency on hi/lo. It is pure logic on busy, md_start and md_op.
- Codes 6/7 with the feature compiled out: treated as no-ops and never start.

Optional Feature:
- Macro MD_MADD_EN.
- When defined:
  - op 6 MADD: {hi,lo} <= {hi,lo} + signed product.
  - op 7 MADDU: {hi,lo} <= {hi,lo} + unsigned product.
  - Both use MULT_CYCLES latency.
  - The accumulate uses the hi/lo values current at the completion edge, which equal the values at start because no other write can occur while busy. The sum wraps modulo 2^64.
- When not defined: codes 6/7 are ignored, stall_req is 0 for them, and hi/lo are untouched.

Test Plan:
- Reset then MULT a=0xFFFF_FFFE(-2), b=3 -> busy high for 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> after 5 cycles hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> busy 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. Then DIVU a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- MULT start, then md_start with DIV on cycles 1..5 of busy -> all ignored; stall_req=1 throughout; the result equals the MULT only; busy low at cycle 6. Then MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle.
- DIV in flight, assert reset at busy cycle 4 -> busy=0, hi=lo=0 immediately (before the next clk edge). After release, no late write occurs at the original completion time.
- With MD_MADD_EN: MTLO 0xFFFF_FFFF, MTHI 0, then MADDU a=1, b=1 -> hi=1, lo=0. Without the macro: same stimulus -> hi=0, lo=0xFFFF_FFFF, busy never asserted.
